// File: rtl/bch_encoder_core.sv
// rtl/bch_encoder_core.sv - BCH(15,7,t=2) systematic encoder, serial LFSR, g(x)=0x1D1
// Optional error injection on the codeword output via BCH_ERR_INJECT_EN.
module bch_encoder_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [6:0]  data_in,
`ifdef BCH_ERR_INJECT_EN
   input  logic [14:0] err_mask,
`endif
   output logic        busy,
   output logic        valid,
   output logic        done,
   output logic [14:0] codeword
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [6:0]  msg;
   logic [7:0]  lfsr;
   logic [7:0]  lfsr_nxt;
   logic [2:0]  bit_cnt;
   logic [14:0] code_reg;
   logic        msg_bit;
   logic        fb;

   // Message is fed MSB first; counter 0 selects the x^6 coefficient.
   assign msg_bit  = msg[3'd6 - bit_cnt];
   assign fb       = msg_bit ^ lfsr[7];
   assign lfsr_nxt = {lfsr[6:0], 1'b0} ^ (fb ? 8'hD1 : 8'h00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (bit_cnt == 3'd6) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         msg      <= 7'd0;
         lfsr     <= 8'd0;
         bit_cnt  <= 3'd0;
         code_reg <= 15'd0;
         busy     <= 1'b0;
         valid    <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  msg     <= data_in;
                  lfsr    <= 8'd0;
                  bit_cnt <= 3'd0;
                  valid   <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            SHIFT: begin
               lfsr    <= lfsr_nxt;
               bit_cnt <= bit_cnt + 3'd1;
            end
            FINISH: begin
               code_reg <= {msg, lfsr};
               valid    <= 1'b1;
               done     <= 1'b1;
               busy     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef BCH_ERR_INJECT_EN
   assign codeword = code_reg ^ err_mask;
`else
   assign codeword = code_reg;
`endif

endmodule
